// File: rtl/fm_carrier_nco.sv
// rtl/fm_carrier_nco.sv - FM carrier NCO: linear deviation interpolation, phase accumulator, sine LUT
`timescale 1ns/1ps
module fm_carrier_nco #(
    parameter int INTERP_LOG2  = 9,
    parameter int NSAMPLES_LUT = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ready_block_192,
    input  logic [23:0] FMout,
    input  logic [31:0] fc_word,
    output logic [23:0] dev,
    output logic [31:0] phase,
    output logic [7:0]  carrier_sine,
    output logic        carrier_sq,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_e;

    // Quarter-wave of round(127*sin(2*pi*k/256)), k = 0..64; the rest follows by symmetry.
    localparam logic [7:0] QTAB [0:64] = '{
        8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
        8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
        8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
        8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
        8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
        8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
        8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127,
        8'd127
    };

    // A shallower LUT keeps only the top log2(NSAMPLES_LUT) phase bits of the 256-entry table.
    localparam int         LUT_AW   = $clog2(NSAMPLES_LUT);
    localparam logic [7:0] LUT_MASK = 8'hFF << (8 - LUT_AW);

    function automatic logic [7:0] sine_at(input logic [7:0] a);
        logic [6:0] qidx;
        logic [7:0] mag;
        qidx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        mag  = QTAB[qidx];
        return a[7] ? (8'd0 - mag) : mag;
    endfunction

    state_e                  state_q, state_d;
    logic                    rdy_q;
    logic                    capture;
    logic signed [23:0]      dev_q, dev_d;
    logic signed [23:0]      target_q, target_d;
    logic signed [23:0]      step_q, step_d;
    logic [INTERP_LOG2-1:0]  cnt_q, cnt_d;
    logic signed [24:0]      diff;
    logic                    busy_q;
    logic [31:0]             inc_q;
    logic [31:0]             phase_q;
    logic [7:0]              sine_q;
    logic [7:0]              lut_addr;

    always_comb begin
        capture  = ready_block_192 & ~rdy_q;
        diff     = {FMout[23], FMout} - {dev_q[23], dev_q};
        lut_addr = phase_q[31:24] & LUT_MASK;
        state_d  = state_q;
        dev_d    = dev_q;
        target_d = target_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        case (state_q)
            RAMP: begin
                if (cnt_q == '0) begin
                    dev_d   = target_q;
                    state_d = HOLD;
                end else begin
                    dev_d = dev_q + step_q;
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
        // A new sample overrides any ramp step; the ramp restarts from the present dev.
        if (capture) begin
            dev_d    = dev_q;
            target_d = FMout;
            step_d   = 24'(diff >>> INTERP_LOG2);
            cnt_d    = '1;
            state_d  = RAMP;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            dev_q    <= '0;
            target_q <= '0;
            step_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            inc_q    <= '0;
            phase_q  <= '0;
            sine_q   <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= ready_block_192;
            dev_q    <= dev_d;
            target_q <= target_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            // Registered so busy covers exactly the clocks whose dev value the ramp produced.
            busy_q   <= (state_q == RAMP);
            inc_q    <= fc_word + {{8{dev_q[23]}}, dev_q};
            phase_q  <= phase_q + inc_q;
            sine_q   <= sine_at(lut_addr);
        end
    end

    assign dev          = dev_q;
    assign phase        = phase_q;
    assign carrier_sine = sine_q;
    assign carrier_sq   = phase_q[31];
    assign busy         = busy_q;

endmodule

// File: tb/tb_fm_carrier_nco.sv
// tb/tb_fm_carrier_nco.sv - directed self-checking bench for fm_carrier_nco
`timescale 1ns/1ps
module tb_fm_carrier_nco;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready_block_192;
    logic [23:0] FMout;
    logic [31:0] fc_word;
    logic [23:0] dev;
    logic [31:0] phase;
    logic [7:0]  carrier_sine;
    logic        carrier_sq;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fm_carrier_nco dut (
        .clock           (clock),
        .reset           (reset),
        .ready_block_192 (ready_block_192),
        .FMout           (FMout),
        .fc_word         (fc_word),
        .dev             (dev),
        .phase           (phase),
        .carrier_sine    (carrier_sine),
        .carrier_sq      (carrier_sq),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_lut(input int a);
        real v;
        int  r;
        v = 127.0 * $sin(2.0 * 3.141592653589793 * a / 256.0);
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(-v + 0.5);
        return 8'(r);
    endfunction

    // One active edge, then sample on the following falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    // Returns sampled just after the capture edge T.
    task automatic pulse(input logic [23:0] fm);
        FMout = fm;
        ready_block_192 = 1'b1;
        tick();
        ready_block_192 = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_phase;
        int          busy_cnt;

        reset = 1'b1;
        ready_block_192 = 1'b0;
        FMout = '0;
        fc_word = 32'h1000_0000;
        adv(3);
        check("rst_dev", dev, 0);
        check("rst_phase", phase, 0);
        check("rst_sine", carrier_sine, 0);
        check("rst_sq", carrier_sq, 0);
        check("rst_busy", busy, 0);

        // Free-running carrier: phase after edge k is (k-1)*fc_word.
        reset = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            exp_phase = 32'(k - 1) * 32'h1000_0000;
            check("fr_phase", phase, exp_phase);
            check("fr_sq", carrier_sq, exp_phase[31]);
            if (k % 8 == 0) begin
                check("fr_dev", dev, 0);
                check("fr_busy", busy, 0);
            end
        end

        // Ramp 0 -> 512, step 1.
        pulse(24'd512);
        check("r1_busy_T", busy, 0);
        check("r1_dev_T", dev, 0);
        adv(1);
        check("r1_dev_T1", dev, 24'd1);
        check("r1_busy_T1", busy, 1);
        adv(510);
        check("r1_dev_T511", dev, 24'd511);
        adv(1);
        check("r1_dev_T512", dev, 24'd512);
        check("r1_busy_T512", busy, 1);
        adv(1);
        check("r1_busy_T513", busy, 0);
        check("r1_inc_T513", dut.inc_q, 32'h1000_0200);
        adv(1);
        check("r1_inc_T514", dut.inc_q, 32'h1000_0200);

        // Back to 0, then 0 -> -512 -> 100.
        pulse(24'd0);
        adv(512);
        check("r2_dev_zero", dev, 0);
        adv(1);
        pulse(24'hFFFE00);
        adv(1);
        check("r3_dev_T1", dev, 24'hFFFFFF);
        adv(511);
        check("r3_dev_T512", dev, 24'hFFFE00);
        adv(1);
        check("r3_busy_T513", busy, 0);
        pulse(24'd100);
        adv(1);
        check("r4_dev_T1", dev, 24'hFFFE01);
        adv(511);
        check("r4_dev_T512", dev, 24'd100);
        adv(1);
        check("r4_busy_T513", busy, 0);

        // Truncation toward -inf overshoots below 0, the final clock snaps to target.
        pulse(24'd0);
        adv(512);
        check("r5_dev_T512", dev, 0);
        adv(1);

        // Retrigger: ramp to 1024 (step 2), new sample 0 captured while dev = 512.
        pulse(24'd1024);
        adv(256);
        check("rt_dev_T256", dev, 24'd512);
        pulse(24'd0);
        check("rt_dev_T2", dev, 24'd512);
        check("rt_busy_T2", busy, 1);
        adv(1);
        check("rt_dev_T2p1", dev, 24'd511);
        adv(255);
        check("rt_dev_T2p256", dev, 24'd256);
        adv(256);
        check("rt_dev_T2p512", dev, 0);
        check("rt_busy_T2p512", busy, 1);
        adv(1);
        check("rt_busy_T2p513", busy, 0);

        // Ready held high for 1000 clocks: a single 512-clock ramp.
        FMout = 24'd1024;
        ready_block_192 = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            busy_cnt += int'(busy);
        end
        check("hold_busy_cycles", 64'(busy_cnt), 512);
        check("hold_dev", dev, 24'd1024);
        ready_block_192 = 1'b0;
        adv(1);

        // Mid-ramp reset, then release with ready still high.
        pulse(24'd2048);
        adv(10);
        check("mr_dev_T10", dev, 24'd1044);
        reset = 1'b1;
        ready_block_192 = 1'b1;
        #1;
        check("mr_dev_async", dev, 0);
        check("mr_phase_async", phase, 0);
        check("mr_sine_async", carrier_sine, 0);
        check("mr_sq_async", carrier_sq, 0);
        check("mr_busy_async", busy, 0);
        @(negedge clock);
        check("mr_dev_held", dev, 0);
        check("mr_busy_held", busy, 0);
        reset = 1'b0;
        tick();
        check("mr_busy_T", busy, 0);
        adv(1);
        check("mr_dev_T1", dev, 24'd4);
        check("mr_busy_T1", busy, 1);
        ready_block_192 = 1'b0;
        adv(600);
        check("mr_dev_final", dev, 24'd2048);

        // LUT walk: one address per clock, sine after edge k is lut[k-2].
        reset = 1'b1;
        fc_word = 32'h0100_0000;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 258; k++) begin
            tick();
            if (k >= 2)
                check($sformatf("lut_%0d", (k - 2) % 256), carrier_sine, exp_lut((k - 2) % 256));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
